decode_exec_reg: RTL

//  Decode->execute pipeline register. Captures one decoded instruction and resolves
//  its operands from the forwarding results of fwd_srca/fwd_srcb.

---
 rtl/decode_exec_reg.sv | 110 +++++++++++
 1 files changed

// File: rtl/decode_exec_reg.sv
// rtl/decode_exec_reg.sv - decode->execute pipeline register
// Operand resolution, load-use bubble insertion, valid/ready hold and flush.
package decode_exec_pkg;
   localparam int XLEN   = 64;
   localparam int REG_AW = 5;
   localparam int CTL_W  = 16;

   typedef logic [XLEN-1:0]   word_t;
   typedef logic [REG_AW-1:0] creg_addr_t;

   typedef struct packed {
      creg_addr_t        ra1;
      creg_addr_t        ra2;
      word_t             rd1;
      word_t             rd2;
      creg_addr_t        dst;
      logic [CTL_W-1:0]  ctl;
      word_t             pc;
      word_t             imm;
   } decode_data_t;

   typedef struct packed {
      logic  enable;
      word_t data;
   } fwd_data_t;
endpackage

module decode_exec_reg
   import decode_exec_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  decode_data_t     dataD,
   input  fwd_data_t        fwd_srca,
   input  fwd_data_t        fwd_srcb,
   input  logic             ex_memread,
   input  creg_addr_t       ex_dst,
   output logic             out_valid,
   input  logic             out_ready,
   output decode_data_t     dataE_in,
   output logic [CNT_W-1:0] lu_stall_cnt
);

   typedef enum logic {RUN, BUBBLE} state_t;

   state_t       stateQ, stateD;
   logic         luHit, slotFree, bubbleCycle;
   word_t        srcA, srcB;
   decode_data_t capture;

   always_comb begin
      srcA = (dataD.ra1 == '0) ? '0 : (fwd_srca.enable ? fwd_srca.data : dataD.rd1);
      srcB = (dataD.ra2 == '0) ? '0 : (fwd_srcb.enable ? fwd_srcb.data : dataD.rd2);
      capture     = dataD;
      capture.rd1 = srcA;
      capture.rd2 = srcB;
   end

   assign luHit    = in_valid && ex_memread && (ex_dst != '0)
                     && ((ex_dst == dataD.ra1) || (ex_dst == dataD.ra2));
   assign slotFree = !out_valid || out_ready;

   always_ff @(posedge clk) begin
      if (reset) stateQ <= RUN;
      else       stateQ <= stateD;
   end

   // A hazard behind a stalled execute waits in RUN; the bubble starts only once the slot frees.
   always_comb begin
      stateD = stateQ;
      case (stateQ)
         RUN:     if (!flush && luHit && slotFree) stateD = BUBBLE;
         BUBBLE:  stateD = RUN;
         default: stateD = RUN;
      endcase
   end

   always_comb begin
      in_ready    = !reset && (stateQ == RUN) && !luHit && slotFree && !flush;
      bubbleCycle = (stateQ == BUBBLE) && !flush;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lu_stall_cnt <= '0;
      end else if (bubbleCycle && (lu_stall_cnt != '1)) begin
         lu_stall_cnt <= lu_stall_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         dataE_in  <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (in_valid && in_ready) begin
         out_valid <= 1'b1;
         dataE_in  <= capture;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
